frame_display_scanner: RTL and testbench
========================================

# frame_display_scanner

Display-side stage that reads the shared 160x120 frame buffers and drives a 640x480 VGA-style raster. Each source pixel is upscaled 4x in both directions. The block generates `display_address` with the same column-major mapping the blur engine uses (addr = y + x*IMG_H). It switches between the source and processed buffers only at frame boundaries, keyed off the blur engine's status, so the display never tears.

## Interface
Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, h front porch
- H_SYNC, 96, h sync width
- H_BACK, 48, h back porch
- V_VISIBLE, 480, active lines
- V_FRONT, 10, v front porch
- V_SYNC, 2, v sync width
- V_BACK, 33, v back porch
- IMG_H, 120, image height (address stride)
- SCALE_SHIFT, 2, log2 upscale factor

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- pix_ce  in  1  pixel-rate clock enable; all state advances only on clk edges with pix_ce=1
- processing_done  in  1  blur engine finished
- processing_active  in  1  blur engine running
- pixel_data  in  24  {R,G,B} read data for `display_address` from the buffer chosen by `buf_sel`
- display_address  out  15  frame buffer read address
- buf_sel  out  1  0 = source buffer, 1 = processed buffer
- rgb  out  24  pixel output, 0 during blanking
- hsync  out  1  active-low
- vsync  out  1  active-low
- de  out  1  data enable (visible region)
- frame_start  out  1  one-clk pulse at raster origin

## Operation
- **Counters:**
  - h_cnt wraps at H_TOT = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800).
  - v_cnt increments on h_cnt wrap and wraps at V_TOT (525).
  - Both advance only on pix_ce.
- **Visibility:** vis = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
- **Sync regions:**
  - hs_n = 0 for H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - vs_n = 0 for lines 490..491.
- **Address:**
  - px = h_cnt >> SCALE_SHIFT (0..159); py = v_cnt >> SCALE_SHIFT (0..119).
  - addr = py + px*IMG_H, computed at 15 bits; maximum value is 19199.
  - addr = 0 when !vis.
- **Pipeline** (each stage advances on pix_ce):
  - Stage A registers display_address <= addr, plus vis/hs_n/vs_n into delay regs.
  - Stage B registers rgb <= vis_A ? pixel_data : 0, hsync <= hs_A, vsync <= vs_A, de <= vis_A.
- **Buffer select:**
  - When pix_ce=1 and h_cnt=0 and v_cnt=0: buf_sel <= processing_done && !processing_active.
  - buf_sel holds for the rest of the frame regardless of input changes.
- **frame_start:**
  - Asserted for exactly one clk on the pix_ce edge where counters are at (0,0).
  - Low otherwise, including when pix_ce=0.
- **Reset** (async, any time, including mid-frame):
  - h_cnt=0, v_cnt=0, delay regs cleared to blank/sync-inactive.
  - Outputs: display_address=0, rgb=0, hsync=1, vsync=1, de=0, buf_sel=0, frame_start=0.
  - After release, the raster restarts at (0,0).

## Timing
- Counter-to-output latency: 2 pix_ce steps. hsync/vsync/de/rgb for counter position N appear after the second pix_ce edge following it.
- display_address leads the corresponding rgb by 1 pix_ce step.
- Memory contract: pixel_data must be valid for the current display_address by the next pix_ce edge. With pix_ce=1 every clk, this requires a 1-clk synchronous read.
- pix_ce=0: every register holds, including outputs and buf_sel.
- buf_sel changes at most once per frame, on the frame_start edge. The buffer mux sees the new select before the first visible address of the frame.
- Simultaneous processing_done rise and frame_start edge: the value sampled on that edge is used.

## Test plan
- **Reset values:** assert rst mid-line with pix_ce=1 -> all outputs take their reset values immediately (async); after release, frame_start pulses on the first pix_ce edge.
- **Address mapping, pix_ce tied 1:**
  - h=0..3, v=0 -> display_address 0.
  - h=4 -> 120.
  - v=4, h=0 -> 1.
  - h=639, v=479 -> 19199.
  - h=640 -> 0.
  - rgb equals the memory model word one clk after each address.
- **Sync/blank:**
  - hsync low for exactly 96 pix_ce steps per line, starting 2 steps after h_cnt=656.
  - vsync low for lines 490..491.
  - de high for 640x480 per frame; rgb=0 whenever de=0.
- **Buffer switching:**
  - processing_done rises mid-frame -> buf_sel stays 0 until the next frame_start, then becomes 1.
  - processing_active=1 at frame_start -> buf_sel=0.
- **Clock enable:** pix_ce=1 every 4th clk -> identical output sequence per pix_ce step as the pix_ce=1 run; frame period = 420000 pix_ce steps.
- **Frame wrap:** run 2 full frames -> frame_start pulses exactly every 800*525 pix_ce steps; counters wrap cleanly from (799,524) to (0,0).

Source files
------------

// File: rtl/frame_display_scanner.sv
// frame_display_scanner
// Reads a column-major 160x120 frame buffer and drives a 640x480 raster with
// 4x upscaling in both directions. The source/processed buffer select is
// latched only at the raster origin, so a frame never mixes the two buffers.
//
// Ports:
//   clk, rst           system clock, asynchronous active-low reset
//   pix_ce             pixel-rate enable; all state advances only when high
//   processing_done    blur engine finished
//   processing_active  blur engine running
//   pixel_data         {R,G,B} read data for display_address
//   display_address    frame buffer read address (y + x*IMG_H)
//   buf_sel            0 = source buffer, 1 = processed buffer
//   rgb                pixel output, 0 during blanking
//   hsync, vsync       active-low sync
//   de                 data enable (visible region)
//   frame_start        one-clk pulse on the pix_ce edge at raster origin
module frame_display_scanner #(
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter int unsigned IMG_H       = 120,
    parameter int unsigned SCALE_SHIFT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_ce,
    input  logic        processing_done,
    input  logic        processing_active,
    input  logic [23:0] pixel_data,
    output logic [14:0] display_address,
    output logic        buf_sel,
    output logic [23:0] rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_start
);

    localparam int unsigned H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HW    = $clog2(H_TOT);
    localparam int unsigned VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [HW-1:0] H_VIS_W  = HW'(H_VISIBLE);
    localparam logic [VW-1:0] V_VIS_W  = VW'(V_VISIBLE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [14:0]   STRIDE   = 15'(IMG_H);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          vis_a_q, vis_a_d;
    logic          hs_a_q, hs_a_d;
    logic          vs_a_q, vs_a_d;
    logic [14:0]   display_address_q, display_address_d;
    logic [23:0]   rgb_q, rgb_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic          buf_sel_q, buf_sel_d;
    logic          frame_start_q, frame_start_d;

    logic        vis, hs_n, vs_n, origin;
    logic [14:0] px, py, addr;

    always_comb begin
        vis    = (h_cnt_q < H_VIS_W) && (v_cnt_q < V_VIS_W);
        hs_n   = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
        vs_n   = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
        origin = (h_cnt_q == '0) && (v_cnt_q == '0);
        px     = 15'(h_cnt_q >> SCALE_SHIFT);
        py     = 15'(v_cnt_q >> SCALE_SHIFT);
        addr   = py + px * STRIDE;
    end

    always_comb begin
        h_cnt_d           = h_cnt_q;
        v_cnt_d           = v_cnt_q;
        vis_a_d           = vis_a_q;
        hs_a_d            = hs_a_q;
        vs_a_d            = vs_a_q;
        display_address_d = display_address_q;
        rgb_d             = rgb_q;
        hsync_d           = hsync_q;
        vsync_d           = vsync_q;
        de_d              = de_q;
        buf_sel_d         = buf_sel_q;
        // frame_start is a single-clk pulse, so it is not held across idle clks
        frame_start_d     = 1'b0;

        if (pix_ce) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
            end else begin
                h_cnt_d = h_cnt_q + HW'(1);
            end

            // Stage A: address and delayed raster flags
            display_address_d = vis ? addr : '0;
            vis_a_d           = vis;
            hs_a_d            = hs_n;
            vs_a_d            = vs_n;

            // Stage B: pixel data arrives one step after its address
            rgb_d   = vis_a_q ? pixel_data : '0;
            hsync_d = hs_a_q;
            vsync_d = vs_a_q;
            de_d    = vis_a_q;

            if (origin) begin
                buf_sel_d     = processing_done && !processing_active;
                frame_start_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt_q           <= '0;
            v_cnt_q           <= '0;
            vis_a_q           <= 1'b0;
            hs_a_q            <= 1'b1;
            vs_a_q            <= 1'b1;
            display_address_q <= '0;
            rgb_q             <= '0;
            hsync_q           <= 1'b1;
            vsync_q           <= 1'b1;
            de_q              <= 1'b0;
            buf_sel_q         <= 1'b0;
            frame_start_q     <= 1'b0;
        end else begin
            h_cnt_q           <= h_cnt_d;
            v_cnt_q           <= v_cnt_d;
            vis_a_q           <= vis_a_d;
            hs_a_q            <= hs_a_d;
            vs_a_q            <= vs_a_d;
            display_address_q <= display_address_d;
            rgb_q             <= rgb_d;
            hsync_q           <= hsync_d;
            vsync_q           <= vsync_d;
            de_q              <= de_d;
            buf_sel_q         <= buf_sel_d;
            frame_start_q     <= frame_start_d;
        end
    end

    assign display_address = display_address_q;
    assign rgb             = rgb_q;
    assign hsync           = hsync_q;
    assign vsync           = vsync_q;
    assign de              = de_q;
    assign buf_sel         = buf_sel_q;
    assign frame_start     = frame_start_q;

endmodule

// File: tb/tb_frame_display_scanner.sv
// Testbench for frame_display_scanner using a reduced raster geometry so
// several whole frames fit in a short run. Expected responses come from a
// bench-side raster model and are queued; a negedge monitor pops and compares.
module tb_frame_display_scanner;

    localparam int HV = 32, HF = 4, HS = 6, HB = 6;
    localparam int VV = 24, VF = 2, VS = 2, VB = 3;
    localparam int IH = 6, SS = 2;
    localparam int HT = HV + HF + HS + HB;   // 48
    localparam int VT = VV + VF + VS + VB;   // 31
    localparam int FRAME = HT * VT;          // 1488

    logic        clk, rst, pix_ce, processing_done, processing_active;
    logic [23:0] pixel_data;
    logic [14:0] display_address;
    logic        buf_sel, hsync, vsync, de, frame_start;
    logic [23:0] rgb;

    frame_display_scanner #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .IMG_H(IH), .SCALE_SHIFT(SS)
    ) dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce),
        .processing_done(processing_done), .processing_active(processing_active),
        .pixel_data(pixel_data), .display_address(display_address),
        .buf_sel(buf_sel), .rgb(rgb), .hsync(hsync), .vsync(vsync),
        .de(de), .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] mem_word(input logic [14:0] a, input logic b);
        return {(b ? 8'hC3 : 8'h3C), 1'b0, a};
    endfunction

    // Memory model: the DUT's address register acts as the read address register
    assign pixel_data = mem_word(display_address, buf_sel);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    typedef struct {
        logic [14:0] addr;
        logic [23:0] rgb;
        logic        hs, vs, de, fs, bs;
        int          h, v;
    } exp_t;

    exp_t q[$];

    // Raster model
    int          mh, mv;
    logic        mb;
    logic        a_vis, a_hs, a_vs, a_b;
    logic [14:0] a_addr;

    always @(posedge clk) begin
        exp_t e;
        logic vis, org;
        if (!rst) begin
            mh = 0; mv = 0; mb = 1'b0;
            a_vis = 1'b0; a_hs = 1'b1; a_vs = 1'b1; a_b = 1'b0; a_addr = '0;
        end else if (pix_ce) begin
            e.h = mh; e.v = mv;
            org = (mh == 0) && (mv == 0);
            if (org) mb = processing_done && !processing_active;
            vis = (mh < HV) && (mv < VV);
            e.addr = vis ? 15'((mv >> SS) + (mh >> SS) * IH) : 15'd0;
            e.fs   = org;
            e.bs   = mb;
            e.rgb  = a_vis ? mem_word(a_addr, a_b) : 24'd0;
            e.hs   = a_hs;
            e.vs   = a_vs;
            e.de   = a_vis;
            q.push_back(e);
            a_vis  = vis;
            a_addr = e.addr;
            a_b    = mb;
            a_hs   = !((mh >= HV + HF) && (mh < HV + HF + HS));
            a_vs   = !((mv >= VV + VF) && (mv < VV + VF + VS));
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
        end
    end

    // Hand-computed address points: (h, v) -> display_address after that step
    int tab_h[8] = '{0, 3, 4, 0, 4, 31, 31, 32};
    int tab_v[8] = '{0, 0, 0, 4, 4, 0, 23, 0};
    int tab_a[8] = '{0, 0, 6, 1, 7, 42, 47, 0};

    // Monitor
    exp_t last;
    bit   have_last = 0;
    bit   seen_fs   = 0;
    int   since_fs  = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            q.delete();
            have_last = 0;
            seen_fs   = 0;
            since_fs  = 0;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            chk("display_address", 32'(display_address), 32'(e.addr));
            chk("rgb",             32'(rgb),             32'(e.rgb));
            chk("hsync",           32'(hsync),           32'(e.hs));
            chk("vsync",           32'(vsync),           32'(e.vs));
            chk("de",              32'(de),              32'(e.de));
            chk("frame_start",     32'(frame_start),     32'(e.fs));
            chk("buf_sel",         32'(buf_sel),         32'(e.bs));
            if (!de) chk("rgb_blank", 32'(rgb), 32'd0);
            for (int i = 0; i < 8; i++)
                if (e.h == tab_h[i] && e.v == tab_v[i])
                    chk("addr_point", 32'(display_address), 32'(tab_a[i]));
            since_fs++;
            if (frame_start) begin
                if (seen_fs) chk("frame_period", 32'(since_fs), 32'(FRAME));
                seen_fs  = 1;
                since_fs = 0;
            end
            last      = e;
            have_last = 1;
        end else if (have_last) begin
            chk("hold_frame_start", 32'(frame_start),     32'd0);
            chk("hold_address",     32'(display_address), 32'(last.addr));
            chk("hold_rgb",         32'(rgb),             32'(last.rgb));
            chk("hold_hsync",       32'(hsync),           32'(last.hs));
            chk("hold_buf_sel",     32'(buf_sel),         32'(last.bs));
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_addr"},  32'(display_address), 32'd0);
        chk({tag, "_rgb"},   32'(rgb),             32'd0);
        chk({tag, "_hsync"}, 32'(hsync),           32'd1);
        chk({tag, "_vsync"}, 32'(vsync),           32'd1);
        chk({tag, "_de"},    32'(de),              32'd0);
        chk({tag, "_bsel"},  32'(buf_sel),         32'd0);
        chk({tag, "_fs"},    32'(frame_start),     32'd0);
    endtask

    initial begin
        rst = 1'b0; pix_ce = 1'b0;
        processing_done = 1'b0; processing_active = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst_init");
        rst = 1'b1;
        pix_ce = 1'b1;

        // Frame 1: done rises mid-frame, select must wait for frame 2
        repeat (FRAME / 2) @(negedge clk);
        processing_done = 1'b1;
        repeat (FRAME) @(negedge clk);
        // Mid frame 2: engine busy again, frame 3 must fall back to source
        processing_active = 1'b1;
        repeat (FRAME) @(negedge clk);
        processing_active = 1'b0;
        repeat (FRAME) @(negedge clk);

        // Asynchronous reset mid-line while buf_sel is 1
        repeat (7) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_reset_outputs("rst_async");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 chk("fs_after_release", 32'(frame_start), 32'd1);
        repeat (FRAME / 3) @(negedge clk);

        // Reduced pixel rate: pix_ce every 4th clk
        for (int i = 0; i < (FRAME + FRAME / 2) * 4; i++) begin
            @(negedge clk);
            pix_ce = (i % 4 == 0);
        end
        @(negedge clk);
        pix_ce = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
